// File: rtl/ble_pkg.sv
// ble_pkg: shared definitions for the BLE UART transmit scheduler.
//   BLE_TERM   - newline byte that terminates every frame on the link
//   BLE_SUBST  - replacement for payload bytes that would look like BLE_TERM
//   byte_t     - one link byte
//   tx_state_t - scheduler states (CSUM is only reachable when the
//                BLE_TX_CHECKSUM_EN build option is defined)
//   subst_byte - applies the lossy 0x0A -> 0x0B substitution
package ble_pkg;

  localparam logic [7:0] BLE_TERM  = 8'h0A;
  localparam logic [7:0] BLE_SUBST = 8'h0B;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    TERM = 2'd3
  } tx_state_t;

  // No escaping is done: a payload 0x0A is simply sent as 0x0B so the
  // ground receiver can never split a frame early.
  function automatic byte_t subst_byte(input byte_t b);
    return (b == BLE_TERM) ? BLE_SUBST : b;
  endfunction

endpackage

// File: rtl/ble_rr_arbiter.sv
// ble_rr_arbiter: combinational round-robin pick.
//   req   [NUM_REQ] - pending requests
//   ptr   [PTR_W]   - highest-priority requester index (0..NUM_REQ-1)
//   grant [NUM_REQ] - one-hot winner: first set req bit searching upward
//                     from ptr, wrapping past NUM_REQ-1 back to 0
//   found           - any request present
// The pointer register itself lives in the scheduler.
module ble_rr_arbiter
  import ble_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               found
);

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ble_tx_scheduler.sv
// ble_tx_scheduler: picks one of NUM_REQ frame requesters round-robin,
// latches its frame into a shadow buffer and streams it byte by byte to
// the UART transmitter, ending each frame with the 0x0A terminator.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   req_valid    - [NUM_REQ] requester i has a frame pending
//   req_frame    - [NUM_REQ*FRAME_LEN*8] packed payloads, byte 0 in the
//                  low 8 bits of each requester slice, sent first
//   req_len      - [NUM_REQ*LEN_W] payload length (clamped to FRAME_LEN)
//   req_grant    - [NUM_REQ] one-hot 1-cycle pulse when a frame is latched
//   tx_data      - byte presented to the transmitter
//   tx_valid     - tx_data valid
//   tx_ready     - transmitter accepts the byte
//   busy         - scheduler is not IDLE
//   frames_sent  - completed frames, wraps 0xFFFF -> 0
//
// Handshake: a byte moves on every clock edge where tx_valid && tx_ready.
// Once tx_valid is raised, tx_data and tx_valid hold until that transfer;
// tx_ready may be driven independently of tx_valid.
//
// Build option BLE_TX_CHECKSUM_EN: when defined, an XOR checksum of the
// emitted (post-substitution) payload bytes, seed 0x00, is sent between
// the payload and the terminator, itself substituted if it equals 0x0A.
module ble_tx_scheduler
  import ble_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int FRAME_LEN = 10,
  parameter int LEN_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*FRAME_LEN*8-1:0] req_frame,
  input  logic [NUM_REQ*LEN_W-1:0]     req_len,
  output logic [NUM_REQ-1:0]           req_grant,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic [15:0]                  frames_sent
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int FW    = FRAME_LEN * 8;

  tx_state_t            state_q, state_n;
  logic [PTR_W-1:0]     rr_q, rr_n, rr_win;
  logic [NUM_REQ-1:0]   grant_q, grant_n;
  logic                 tx_valid_q, tx_valid_n;
  byte_t                tx_data_q, tx_data_n;
  logic [15:0]          frames_q, frames_n;
  logic [FW-1:0]        frame_q, frame_n, sel_frame;
  logic [LEN_W-1:0]     len_q, len_n, sel_len, sel_len_c;
  logic [LEN_W-1:0]     idx_q, idx_n, idx_inc;
  logic [NUM_REQ-1:0]   win_oh;
  logic                 found;
  logic                 xfer;
  logic                 last;
  byte_t                next_byte;
`ifdef BLE_TX_CHECKSUM_EN
  byte_t                csum_q, csum_n, csum_acc;
`endif

  ble_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_q),
    .grant (win_oh),
    .found (found)
  );

  // Mux the winner's frame/length and the pointer value that follows it.
  always_comb begin
    sel_frame = '0;
    sel_len   = '0;
    rr_win    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        sel_frame = req_frame[i*FW +: FW];
        sel_len   = req_len[i*LEN_W +: LEN_W];
        rr_win    = PTR_W'((i + 1) % NUM_REQ);
      end
    end
  end

  assign sel_len_c = (sel_len > LEN_W'(FRAME_LEN)) ? LEN_W'(FRAME_LEN) : sel_len;
  assign xfer      = tx_valid_q && tx_ready;
  assign idx_inc   = idx_q + LEN_W'(1);
  assign last      = (idx_inc == len_q);
  assign next_byte = subst_byte(byte_t'(frame_q >> {idx_inc, 3'b000}));
`ifdef BLE_TX_CHECKSUM_EN
  assign csum_acc  = csum_q ^ tx_data_q;
`endif

  always_comb begin
    state_n    = state_q;
    rr_n       = rr_q;
    grant_n    = '0;
    tx_valid_n = tx_valid_q;
    tx_data_n  = tx_data_q;
    frames_n   = frames_q;
    frame_n    = frame_q;
    len_n      = len_q;
    idx_n      = idx_q;
`ifdef BLE_TX_CHECKSUM_EN
    csum_n     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_n    = win_oh;
          rr_n       = rr_win;
          frame_n    = sel_frame;
          len_n      = sel_len_c;
          idx_n      = '0;
          tx_valid_n = 1'b1;
`ifdef BLE_TX_CHECKSUM_EN
          csum_n     = 8'h00;
`endif
          if (sel_len_c == '0) begin
`ifdef BLE_TX_CHECKSUM_EN
            // Empty payload: checksum of nothing is the seed.
            state_n   = CSUM;
            tx_data_n = 8'h00;
`else
            state_n   = TERM;
            tx_data_n = BLE_TERM;
`endif
          end else begin
            state_n   = SEND;
            tx_data_n = subst_byte(sel_frame[7:0]);
          end
        end
      end
      SEND: begin
        if (xfer) begin
`ifdef BLE_TX_CHECKSUM_EN
          csum_n = csum_acc;
`endif
          if (last) begin
`ifdef BLE_TX_CHECKSUM_EN
            state_n   = CSUM;
            tx_data_n = subst_byte(csum_acc);
`else
            state_n   = TERM;
            tx_data_n = BLE_TERM;
`endif
          end else begin
            idx_n     = idx_inc;
            tx_data_n = next_byte;
          end
        end
      end
      CSUM: begin
`ifdef BLE_TX_CHECKSUM_EN
        if (xfer) begin
          state_n   = TERM;
          tx_data_n = BLE_TERM;
        end
`else
        state_n    = IDLE;
        tx_valid_n = 1'b0;
`endif
      end
      TERM: begin
        if (xfer) begin
          state_n    = IDLE;
          tx_valid_n = 1'b0;
          tx_data_n  = 8'h00;
          frames_n   = frames_q + 16'd1;
        end
      end
      default: begin
        state_n    = IDLE;
        tx_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      frames_q   <= 16'd0;
      len_q      <= '0;
      idx_q      <= '0;
`ifdef BLE_TX_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_n;
      rr_q       <= rr_n;
      grant_q    <= grant_n;
      tx_valid_q <= tx_valid_n;
      tx_data_q  <= tx_data_n;
      frames_q   <= frames_n;
      len_q      <= len_n;
      idx_q      <= idx_n;
`ifdef BLE_TX_CHECKSUM_EN
      csum_q     <= csum_n;
`endif
    end
  end

  // Shadow payload needs no reset: it is always loaded before it is read.
  always_ff @(posedge clk) begin
    frame_q <= frame_n;
  end

  assign req_grant   = grant_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign busy        = (state_q != IDLE);
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_ble_tx_scheduler.sv
// tb_ble_tx_scheduler: directed bench for ble_tx_scheduler with default
// parameters (3 requesters, 10-byte frames). Inputs change 1 time unit
// after the rising edge; outputs are observed on the falling edge.
module tb_ble_tx_scheduler;

  localparam int NUM_REQ   = 3;
  localparam int FRAME_LEN = 10;
  localparam int LEN_W     = 4;
`ifdef BLE_TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*FRAME_LEN*8-1:0] req_frame;
  logic [NUM_REQ*LEN_W-1:0]       req_len;
  logic [NUM_REQ-1:0]             req_grant;
  logic [7:0]                     tx_data;
  logic                           tx_valid;
  logic                           tx_ready;
  logic                           busy;
  logic [15:0]                    frames_sent;

  int n_cmp;
  int n_fail;
  int cyc = 0;

  logic [7:0]         got_q[$];
  int                 got_cyc[$];
  logic [NUM_REQ-1:0] gnt_q[$];
  int                 gnt_cyc[$];
  logic [7:0]         exp_q[$];

  ble_tx_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .FRAME_LEN (FRAME_LEN),
    .LEN_W     (LEN_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_frame   (req_frame),
    .req_len     (req_len),
    .req_grant   (req_grant),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: log grants and byte transfers with their cycle number.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (req_grant != '0) begin
      gnt_q.push_back(req_grant);
      gnt_cyc.push_back(cyc);
    end
    if (tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      got_cyc.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    gnt_q.delete();
    gnt_cyc.delete();
    exp_q.delete();
  endtask

  task automatic set_req(input int r, input int len, input logic [79:0] bytes);
    req_frame[r*80 +: 80] = bytes;
    req_len[r*4 +: 4]     = 4'(len);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (req_grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tx_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Tests
  task automatic test_reset();
    n_cmp++;
    if (req_grant !== 3'b000 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        busy !== 1'b0 || frames_sent !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: grant=%b valid=%b data=%02h busy=%b frames=%0d, expected all zero",
               req_grant, tx_valid, tx_data, busy, frames_sent);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b valid=%b, expected 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    set_req(0, 3, 80'h33_22_11);
    tx_ready  = 1'b1;
    req_valid = 3'b001;
    wait_grant(ok);
    req_valid = '0;
    n_cmp++;
    if (!ok || req_grant !== 3'b001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b busy=%b ok=%0d, expected 001 1 1", req_grant, busy, ok);
    end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_idle: busy still %b after timeout, expected 0", busy);
    end
    exp_q = '{8'h11, 8'h22, 8'h33};
    if (CS != 0) exp_q.push_back(8'h00);
    exp_q.push_back(8'h0A);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] != gnt_cyc[0] + i) begin
        n_fail++;
        $display("FAIL single_byte%0d: got %02h at cycle %0d, expected %02h at cycle %0d",
                 i, got_q[i], got_cyc[i], exp_q[i], gnt_cyc[0] + i);
      end
    end
    n_cmp++;
    if (gnt_q.size() != 1 || frames_sent !== 16'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: grants=%0d frames=%0d busy=%b, expected 1 1 0",
               gnt_q.size(), frames_sent, busy);
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_logs();
    set_req(0, 3, 80'h33_22_11);
    tx_ready  = 1'b1;
    req_valid = 3'b001;
    wait_grant(ok);
    req_valid = '0;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b data=%02h, expected 1 22", i, tx_valid, tx_data);
      end
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle(ok);
    exp_q = '{8'h11, 8'h22, 8'h33};
    if (CS != 0) exp_q.push_back(8'h00);
    exp_q.push_back(8'h0A);
    n_cmp++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stall_count: got %0d bytes ok=%0d, expected %0d", got_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_byte%0d: got %02h, expected %02h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (frames_sent !== 16'd2) begin
      n_fail++;
      $display("FAIL stall_frames: got %0d, expected 2", frames_sent);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int n;
    int flen;
    logic [NUM_REQ-1:0] exp_g[4];
    logic [7:0] pay[4];
    do_reset();
    clear_logs();
    set_req(0, 1, 80'hA0);
    set_req(1, 1, 80'hB0);
    set_req(2, 1, 80'hC0);
    req_valid = 3'b111;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(posedge clk); #1;
      if (req_grant != '0) n++;
    end
    req_valid = '0;
    wait_idle(ok);
    n_cmp++;
    if (n != 4 || !ok || gnt_q.size() != 4) begin
      n_fail++;
      $display("FAIL rr_count: grants=%0d logged=%0d ok=%0d, expected 4 4 1", n, gnt_q.size(), ok);
    end
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    pay   = '{8'hA0, 8'hB0, 8'hC0, 8'hA0};
    flen  = 2 + CS;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(pay[k]);
      if (CS != 0) exp_q.push_back(pay[k]);
      exp_q.push_back(8'h0A);
    end
    for (int k = 0; k < 4 && k < gnt_q.size(); k++) begin
      n_cmp++;
      if (gnt_q[k] !== exp_g[k]) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b, expected %b", k, gnt_q[k], exp_g[k]);
      end
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rr_bytes: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rr_byte%0d: got %02h, expected %02h", i, got_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < 3 && k + 1 < gnt_q.size() && k * flen + flen - 1 < got_q.size(); k++) begin
      n_cmp++;
      if (gnt_cyc[k+1] - got_cyc[k*flen + flen - 1] < 2) begin
        n_fail++;
        $display("FAIL rr_gap%0d: grant %0d cycles after terminator, expected at least 2",
                 k, gnt_cyc[k+1] - got_cyc[k*flen + flen - 1]);
      end
    end
    n_cmp++;
    if (frames_sent !== 16'd4) begin
      n_fail++;
      $display("FAIL rr_frames: got %0d, expected 4", frames_sent);
    end
  endtask

  task automatic test_subst();
    bit ok;
    clear_logs();
    set_req(1, 4, 80'h42_0A_41_0A);
    req_valid = 3'b010;
    wait_grant(ok);
    req_valid = '0;
    n_cmp++;
    if (!ok || req_grant !== 3'b010) begin
      n_fail++;
      $display("FAIL subst_grant: got %b, expected 010", req_grant);
    end
    wait_idle(ok);
    exp_q = '{8'h0B, 8'h41, 8'h0B, 8'h42};
    if (CS != 0) exp_q.push_back(8'h03);
    exp_q.push_back(8'h0A);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL subst_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL subst_byte%0d: got %02h, expected %02h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_clamp();
    bit ok;
    clear_logs();
    set_req(0, 15, 80'h0A_09_08_07_06_05_04_03_02_01);
    req_valid = 3'b001;
    wait_grant(ok);
    req_valid = '0;
    wait_idle(ok);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0B};
    if (CS != 0) exp_q.push_back(8'h0B);
    exp_q.push_back(8'h0A);
    n_cmp++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL clamp_count: got %0d bytes ok=%0d, expected %0d", got_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL clamp_byte%0d: got %02h, expected %02h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    bit ok;
    clear_logs();
    set_req(2, 0, 80'h0);
    req_valid = 3'b100;
    wait_grant(ok);
    req_valid = '0;
    wait_idle(ok);
    if (CS != 0) exp_q.push_back(8'h00);
    exp_q.push_back(8'h0A);
    n_cmp++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL len0_count: got %0d bytes ok=%0d, expected %0d", got_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL len0_byte%0d: got %02h, expected %02h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (frames_sent !== 16'd7) begin
      n_fail++;
      $display("FAIL len0_frames: got %0d, expected 7", frames_sent);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    clear_logs();
    set_req(2, 5, 80'h05_04_03_02_01);
    req_valid = 3'b100;
    wait_grant(ok);
    @(posedge clk);
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0 || frames_sent !== 16'd0 || busy !== 1'b0 || req_grant !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_values: valid=%b frames=%0d busy=%b grant=%b, expected 0 0 0 000",
               tx_valid, frames_sent, busy, req_grant);
    end
    exp_q = '{8'h01, 8'h02};
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      n_fail++;
      $display("FAIL midreset_partial: got %0d bytes, expected exactly 01 02", got_q.size());
    end
    clear_logs();
    set_req(0, 1, 80'h5A);
    req_valid = 3'b101;
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(ok);
    n_cmp++;
    if (!ok || req_grant !== 3'b001) begin
      n_fail++;
      $display("FAIL midreset_first_grant: got %b, expected 001", req_grant);
    end
    req_valid = '0;
    wait_idle(ok);
    exp_q = '{8'h5A};
    if (CS != 0) exp_q.push_back(8'h5A);
    exp_q.push_back(8'h0A);
    n_cmp++;
    if (!ok || got_q.size() != exp_q.size() || got_q[0] !== exp_q[0] ||
        got_q[got_q.size()-1] !== 8'h0A || frames_sent !== 16'd1) begin
      n_fail++;
      $display("FAIL midreset_after: bytes=%0d frames=%0d, expected %0d bytes starting 5a ending 0a and 1 frame",
               got_q.size(), frames_sent, exp_q.size());
    end
  endtask

`ifdef BLE_TX_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    clear_logs();
    set_req(0, 3, 80'h04_02_01);
    req_valid = 3'b001;
    wait_grant(ok);
    req_valid = '0;
    wait_idle(ok);
    set_req(0, 2, 80'h0F_05);
    req_valid = 3'b001;
    wait_grant(ok);
    req_valid = '0;
    wait_idle(ok);
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h07, 8'h0A, 8'h05, 8'h0F, 8'h0B, 8'h0A};
    n_cmp++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL csum_count: got %0d bytes ok=%0d, expected %0d", got_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL csum_byte%0d: got %02h, expected %02h", i, got_q[i], exp_q[i]);
      end
    end
  endtask
`endif

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_frame = '0;
    req_len   = '0;
    tx_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_stall();
    test_round_robin();
    test_subst();
    test_clamp();
    test_len_zero();
    test_reset_mid_frame();
`ifdef BLE_TX_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
